banked_mem_responder: RTL and testbench

//  Memory-side responder for the direct-mapped cache miss/writeback FSM: a 4-bank interleaved

---
 rtl/banked_mem_responder_pkg.sv | 26 ++
 rtl/banked_mem_responder_bank.sv | 56 +++++
 rtl/banked_mem_responder.sv | 100 ++++++++++
 tb/tb_banked_mem_responder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/banked_mem_responder_pkg.sv
// ============================================================================
// Module      : banked_mem_responder_pkg
// Description : Shared constants and types for the 4-bank interleaved memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package banked_mem_responder_pkg;

   localparam int NUM_BANKS    = 4;
   localparam int BANK_W       = 2;
   localparam int BANK_SEL_LSB = 1;
   localparam int BUSY_CY      = 4;
   localparam int RD_LAT       = 2;
   localparam int ADDR_W       = 16;

   typedef logic [BANK_W-1:0] bank_idx_t;

   // Adjacent words of a line fall into adjacent banks.
   function automatic bank_idx_t bank_of(input logic [ADDR_W-1:0] a);
      return a[BANK_SEL_LSB +: BANK_W];
   endfunction

endpackage : banked_mem_responder_pkg

`default_nettype wire

// File: rtl/banked_mem_responder_bank.sv
// ============================================================================
// Module      : banked_mem_responder_bank
// Description : One memory bank: word array, occupancy counter, read register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module banked_mem_responder_bank #(
   parameter int ROW_W   = 8,
   parameter int DATA_W  = 16,
   parameter int BUSY_CY = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_accept,
   input  logic              i_we,
   input  logic [ROW_W-1:0]  i_row,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_busy
);

   localparam int c_CNT_W = (BUSY_CY > 2) ? $clog2(BUSY_CY) : 1;
   localparam logic [c_CNT_W-1:0] c_BUSY_LOAD = c_CNT_W'(BUSY_CY - 1);

   logic [c_CNT_W-1:0] r_cnt;
   logic [DATA_W-1:0]  r_mem [2**ROW_W];
   logic [DATA_W-1:0]  r_rdata;

   // Counter covers the cycles after the request cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_accept) begin
         r_cnt <= c_BUSY_LOAD;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - c_CNT_W'(1);
      end
   end

   // Array contents survive reset.
   always_ff @(posedge clk) begin
      if (i_accept && i_we) begin
         r_mem[i_row] <= i_wdata;
      end
      if (i_accept && !i_we) begin
         r_rdata <= r_mem[i_row];
      end
   end

   assign o_busy  = (r_cnt != '0);
   assign o_rdata = r_rdata;

endmodule : banked_mem_responder_bank

`default_nettype wire

// File: rtl/banked_mem_responder.sv
// ============================================================================
// Module      : banked_mem_responder
// Description : 4-bank interleaved word memory answering cache miss/writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module banked_mem_responder
   import banked_mem_responder_pkg::*;
#(
   parameter int ROW_W  = 8,
   parameter int DATA_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [DATA_W-1:0]    data_in,
   input  logic                 rd,
   input  logic                 wr,
   output logic [DATA_W-1:0]    data_out,
   output logic                 rd_valid,
   output logic [NUM_BANKS-1:0] busy,
   output logic                 stall,
   output logic                 err
);

   localparam int c_ROW_LSB = BANK_SEL_LSB + BANK_W;

   logic                 w_req;
   logic                 w_accept;
   bank_idx_t            w_bank;
   logic [ROW_W-1:0]     w_row;
   logic [NUM_BANKS-1:0] w_busy;
   logic [DATA_W-1:0]    w_bank_rdata [NUM_BANKS];

   logic [RD_LAT-1:0]    r_vld;
   bank_idx_t            r_rd_bank;
   logic [DATA_W-1:0]    r_dq [RD_LAT-1];

   assign w_req    = rd | wr;
   assign w_bank   = bank_of(addr);
   assign w_row    = addr[c_ROW_LSB +: ROW_W];
   assign err      = w_req & ((rd & wr) | addr[0]);
   assign stall    = w_req & ~err & w_busy[w_bank];
   assign w_accept = w_req & ~err & ~w_busy[w_bank];
   assign busy     = w_busy;

   generate
      for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
         banked_mem_responder_bank #(
            .ROW_W   (ROW_W),
            .DATA_W  (DATA_W),
            .BUSY_CY (BUSY_CY)
         ) u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_accept (w_accept && (w_bank == bank_idx_t'(g))),
            .i_we     (wr),
            .i_row    (w_row),
            .i_wdata  (data_in),
            .o_rdata  (w_bank_rdata[g]),
            .o_busy   (w_busy[g])
         );
      end
   endgenerate

   // Upper address bits alias onto the same rows.
   generate
      if (c_ROW_LSB + ROW_W < ADDR_W) begin : g_alias
         logic w_unused_addr;
         assign w_unused_addr = ^addr[ADDR_W-1:c_ROW_LSB+ROW_W];
      end
   endgenerate

   // Stage 0 is the bank's own read register; later stages live here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld     <= '0;
         r_rd_bank <= '0;
         for (int i = 0; i < RD_LAT - 1; i++) begin
            r_dq[i] <= '0;
         end
      end else begin
         r_vld <= {r_vld[RD_LAT-2:0], w_accept & rd};
         if (w_accept && rd) begin
            r_rd_bank <= w_bank;
         end
         r_dq[0] <= w_bank_rdata[r_rd_bank];
         for (int i = 1; i < RD_LAT - 1; i++) begin
            r_dq[i] <= r_dq[i-1];
         end
      end
   end

   assign rd_valid = r_vld[RD_LAT-1];
   assign data_out = rd_valid ? r_dq[RD_LAT-2] : '0;

endmodule : banked_mem_responder

`default_nettype wire

// File: tb/tb_banked_mem_responder.sv
// ============================================================================
// Module      : tb_banked_mem_responder
// Description : Scoreboard bench for banked_mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_banked_mem_responder;

   logic        clk;
   logic        rst_n;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic        rd;
   logic        wr;
   logic [15:0] data_out;
   logic        rd_valid;
   logic [3:0]  busy;
   logic        stall;
   logic        err;

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] model [bit [9:0]];
   int          cyc;
   int          n_checks;
   int          n_fail;

   banked_mem_responder #(.ROW_W(8), .DATA_W(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .addr     (addr),
      .data_in  (data_in),
      .rd       (rd),
      .wr       (wr),
      .data_out (data_out),
      .rd_valid (rd_valid),
      .busy     (busy),
      .stall    (stall),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Every cycle: either the scheduled return appears, or the output is quiet.
   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         n_checks++;
         if (rd_valid !== 1'b1 || data_out !== sb[0].data) begin
            n_fail++;
            $display("FAIL return cyc=%0d: rd_valid=%b data_out=%h, required 1 / %h",
                     cyc, rd_valid, data_out, sb[0].data);
         end
         void'(sb.pop_front());
      end else begin
         n_checks++;
         if (rd_valid !== 1'b0 || data_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL quiet cyc=%0d: rd_valid=%b data_out=%h, required 0 / 0000",
                     cyc, rd_valid, data_out);
         end
      end
   end

   // acc=1: the bench expects this request to be accepted and (for reads) returned.
   task automatic drive(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input bit acc);
      @(posedge clk);
      #1;
      rd = r; wr = w; addr = a; data_in = d;
      if (acc && r) sb.push_back('{data: model[a[10:1]], cyc: cyc + 2});
      if (acc && w) model[a[10:1]] = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
   endtask

   task automatic test_reset;
      idle(3);
      @(negedge clk);
      n_checks++;
      if (busy !== 4'b0000 || rd_valid !== 1'b0 || data_out !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_init: busy=%b rd_valid=%b data_out=%h, required 0000/0/0000",
                  busy, rd_valid, data_out);
      end
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 16'h0020, 16'h1111, 1'b1);
      drive(1'b1, 1'b0, 16'h0022, 16'h0000, 1'b0);
      @(posedge clk);
      #1;
      rd = 1'b0; wr = 1'b0;
      #1;
      rst_n = 1'b0;
      sb.delete();
      #1;
      n_checks++;
      if (busy !== 4'b0000 || rd_valid !== 1'b0 || data_out !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_mid: busy=%b rd_valid=%b data_out=%h, required 0000/0/0000",
                  busy, rd_valid, data_out);
      end
      idle(2);
      #1 rst_n = 1'b1;
      idle(4);
   endtask

   task automatic test_write_read;
      drive(1'b0, 1'b1, 16'h0010, 16'h1234, 1'b1);
      @(negedge clk);
      n_checks++;
      if (busy !== 4'b0000) begin
         n_fail++;
         $display("FAIL wr_busy_t0: busy=%b, required 0000", busy);
      end
      for (int k = 1; k <= 3; k++) begin
         idle(1);
         @(negedge clk);
         n_checks++;
         if (busy !== 4'b0001) begin
            n_fail++;
            $display("FAIL wr_busy_t%0d: busy=%b, required 0001", k, busy);
         end
      end
      drive(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b0 || busy !== 4'b0000) begin
         n_fail++;
         $display("FAIL rd_t4: stall=%b busy=%b, required 0 / 0000", stall, busy);
      end
      idle(4);
      drive(1'b1, 1'b0, 16'h0810, 16'h0000, 1'b1);
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL alias_rd: stall=%b err=%b, required 0 / 0", stall, err);
      end
      idle(4);
   endtask

   task automatic test_line_fill;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 16'h0040 + 16'(2*i), 16'hA000 + 16'(i), 1'b1);
         @(negedge clk);
         n_checks++;
         if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_wr%0d: stall=%b, required 0", i, stall);
         end
      end
      idle(4);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 16'h0040 + 16'(2*i), 16'h0000, 1'b1);
         @(negedge clk);
         n_checks++;
         if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_rd%0d: stall=%b, required 0", i, stall);
         end
      end
      n_checks++;
      if (busy !== 4'b0111) begin
         n_fail++;
         $display("FAIL fill_busy_t3: busy=%b, required 0111", busy);
      end
      idle(1);
      @(negedge clk);
      n_checks++;
      if (busy !== 4'b1110) begin
         n_fail++;
         $display("FAIL fill_busy_t4: busy=%b, required 1110", busy);
      end
      idle(5);
   endtask

   task automatic test_conflict;
      drive(1'b0, 1'b1, 16'h0008, 16'h5A5A, 1'b1);
      idle(4);
      drive(1'b0, 1'b1, 16'h0000, 16'hC0DE, 1'b1);
      for (int k = 1; k <= 3; k++) begin
         drive(1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0);
         @(negedge clk);
         n_checks++;
         if (stall !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_t%0d: stall=%b err=%b, required 1 / 0", k, stall, err);
         end
      end
      drive(1'b1, 1'b0, 16'h0008, 16'h0000, 1'b1);
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b0) begin
         n_fail++;
         $display("FAIL conflict_t4: stall=%b, required 0", stall);
      end
      idle(4);
   endtask

   task automatic test_err;
      drive(1'b0, 1'b1, 16'h0002, 16'h7777, 1'b1);
      idle(4);
      drive(1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0);
      @(negedge clk);
      n_checks++;
      if (err !== 1'b1 || stall !== 1'b0 || busy !== 4'b0000) begin
         n_fail++;
         $display("FAIL err_odd: err=%b stall=%b busy=%b, required 1/0/0000", err, stall, busy);
      end
      drive(1'b1, 1'b1, 16'h0002, 16'hDEAD, 1'b0);
      @(negedge clk);
      n_checks++;
      if (err !== 1'b1 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL err_rdwr: err=%b stall=%b, required 1 / 0", err, stall);
      end
      idle(1);
      @(negedge clk);
      n_checks++;
      if (busy !== 4'b0000) begin
         n_fail++;
         $display("FAIL err_nostate: busy=%b, required 0000", busy);
      end
      drive(1'b0, 1'b1, 16'h0012, 16'h0101, 1'b1);
      drive(1'b1, 1'b0, 16'h0013, 16'h0000, 1'b0);
      @(negedge clk);
      n_checks++;
      if (err !== 1'b1 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL err_prio: err=%b stall=%b, required 1 / 0", err, stall);
      end
      idle(4);
      drive(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1);
      idle(4);
   endtask

   task automatic test_reset_mid_read;
      drive(1'b0, 1'b1, 16'h0004, 16'hBEEF, 1'b1);
      idle(4);
      drive(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0);
      @(posedge clk);
      #1;
      rd = 1'b0; wr = 1'b0;
      #1;
      rst_n = 1'b0;
      sb.delete();
      #1;
      n_checks++;
      if (rd_valid !== 1'b0 || busy !== 4'b0000) begin
         n_fail++;
         $display("FAIL rst_read_drop: rd_valid=%b busy=%b, required 0 / 0000", rd_valid, busy);
      end
      idle(2);
      #1 rst_n = 1'b1;
      idle(2);
      drive(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b1);
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_reread: stall=%b, required 0", stall);
      end
      idle(5);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      rd       = 1'b0;
      wr       = 1'b0;
      addr     = 16'h0000;
      data_in  = 16'h0000;
      test_reset();
      test_write_read();
      test_line_fill();
      test_conflict();
      test_err();
      test_reset_mid_read();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL leftover: %0d returns outstanding, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_banked_mem_responder

`default_nettype wire
